// File: rtl/bus_resolver_pkg.sv
// Shared types for the bus_resolver block: operating mode and arbitration FSM state.
package bus_resolver_pkg;

  typedef enum logic {
    MODE_RESOLVE   = 1'b0,
    MODE_ARBITRATE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

endpackage

// File: rtl/bus_resolver_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant for the first requester at or after ptr (wrapping).
module rr_arbiter #(
  parameter int NUM_DRV = 4,
  parameter int PTR_W   = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1
) (
  input  logic [NUM_DRV-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_DRV-1:0] grant
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_DRV)) sum = sum - (PTR_W+1)'(NUM_DRV);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_resolver.sv
// Clocked multi-driver bus: wired-bus resolution with conflict stats, or round-robin ownership.
// Handshake: no ready; bus_valid qualifies bus_out in the cycle after the sources were sampled.
module bus_resolver
  import bus_resolver_pkg::*;
#(
  parameter int NUM_DRV = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8,
  parameter int KEEPER  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [NUM_DRV-1:0]       drv_en,
  input  logic [NUM_DRV*WIDTH-1:0] drv_data,
  input  logic                     clr_stat,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [NUM_DRV-1:0]       grant,
  output logic [WIDTH-1:0]         conflict_mask,
  output logic                     contention,
  output logic                     contention_sticky,
  output logic [CNT_W-1:0]         contention_cnt,
  output state_e                   state_dbg
);

  localparam int PTR_W = $clog2(NUM_DRV);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_inc, arb_ptr, arb_idx;
  logic [NUM_DRV-1:0] arb_grant, grant_q, grant_d;
  logic [WIDTH-1:0]   bus_q, bus_d, mask_q, mask_d;
  logic [WIDTH-1:0]   and_v, or_v, low_v;
  logic               low_found;
  logic               valid_q, valid_d, con_q, con_d, sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign owner_inc = (owner_q == PTR_W'(NUM_DRV-1)) ? '0 : owner_q + PTR_W'(1);
  // After an owner lets go, the search starts just past it, which is also the new rr_ptr.
  assign arb_ptr   = (state_q == ST_OWNED) ? owner_inc : rr_ptr_q;

  rr_arbiter #(.NUM_DRV(NUM_DRV), .PTR_W(PTR_W)) u_arb (
    .req   (drv_en),
    .ptr   (arb_ptr),
    .grant (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (arb_grant[i]) arb_idx = PTR_W'(i);
    end
  end

  // Disagreement on a bit shows up as AND != OR over the enabled drivers.
  always_comb begin
    and_v     = '1;
    or_v      = '0;
    low_v     = '0;
    low_found = 1'b0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (drv_en[i]) begin
        and_v = and_v & drv_data[i*WIDTH +: WIDTH];
        or_v  = or_v  | drv_data[i*WIDTH +: WIDTH];
        if (!low_found) low_v = drv_data[i*WIDTH +: WIDTH];
        low_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    valid_d  = 1'b0;
    mask_d   = '0;
    bus_d    = (KEEPER != 0) ? bus_q : '0;
    if (mode_e'(mode) == MODE_RESOLVE) begin
      state_d = ST_IDLE;
      grant_d = '0;
      if (|drv_en) begin
        bus_d   = low_v;
        valid_d = 1'b1;
        mask_d  = and_v ^ or_v;
      end
    end else if (state_q == ST_OWNED && drv_en[owner_q]) begin
      bus_d   = drv_data[int'(owner_q)*WIDTH +: WIDTH];
      valid_d = 1'b1;
    end else begin
      if (state_q == ST_OWNED) rr_ptr_d = owner_inc;
      if (|drv_en) begin
        state_d = ST_OWNED;
        owner_d = arb_idx;
        grant_d = arb_grant;
        bus_d   = drv_data[int'(arb_idx)*WIDTH +: WIDTH];
        valid_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end
  end

  // clr_stat wins over a same-cycle event, but the contention pulse itself still fires.
  always_comb begin
    con_d    = |mask_d;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_stat) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (con_d) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      mask_q   <= '0;
      con_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      con_q    <= con_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus_out           = bus_q;
  assign bus_valid         = valid_q;
  assign grant             = grant_q;
  assign conflict_mask     = mask_q;
  assign contention        = con_q;
  assign contention_sticky = sticky_q;
  assign contention_cnt    = cnt_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_bus_resolver.sv
// Bench for bus_resolver: reference model feeds an expected queue, outputs are checked one cycle later.
module tb_bus_resolver;
  import bus_resolver_pkg::*;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CW    = 2;
  localparam int EXP_W = W + 1 + N + W + 1 + 1 + CW;

  logic           clk, rst_n, mode, clr_stat;
  logic [N-1:0]   drv_en;
  logic [N*W-1:0] drv_data;
  logic [W-1:0]   bus_out, conflict_mask;
  logic           bus_valid, contention, contention_sticky;
  logic [N-1:0]   grant;
  logic [CW-1:0]  contention_cnt;
  state_e         state_dbg;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit             m_owned;
  int             m_owner, m_rr;
  logic [W-1:0]   m_bus;
  logic           m_sticky;
  logic [CW-1:0]  m_cnt;

  bus_resolver #(.NUM_DRV(N), .WIDTH(W), .CNT_W(CW), .KEEPER(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mode              (mode),
    .drv_en            (drv_en),
    .drv_data          (drv_data),
    .clr_stat          (clr_stat),
    .bus_out           (bus_out),
    .bus_valid         (bus_valid),
    .grant             (grant),
    .conflict_mask     (conflict_mask),
    .contention        (contention),
    .contention_sticky (contention_sticky),
    .contention_cnt    (contention_cnt),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic model_reset();
    m_owned  = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    m_bus    = '0;
    m_sticky = 1'b0;
    m_cnt    = '0;
  endtask

  task automatic model_step(input bit md, input logic [N-1:0] en, input logic [N*W-1:0] d,
                            input bit clr);
    logic [W-1:0] e_bus, e_mask;
    logic         e_valid, e_con;
    logic [N-1:0] e_grant;
    bit           found;
    int           idx;
    e_bus = m_bus; e_mask = '0; e_valid = 1'b0; e_grant = '0; found = 1'b0;
    if (!md) begin
      m_owned = 1'b0;
      if (en != '0) begin
        for (int k = 0; k < N; k++)
          if (en[k] && !found) begin e_bus = d[k*W +: W]; found = 1'b1; end
        for (int k = 0; k < N; k++)
          if (en[k]) e_mask = e_mask | (e_bus ^ d[k*W +: W]);
        e_valid = 1'b1;
      end
    end else if (m_owned && en[m_owner]) begin
      e_bus = d[m_owner*W +: W]; e_valid = 1'b1; e_grant[m_owner] = 1'b1;
    end else begin
      if (m_owned) m_rr = (m_owner + 1) % N;
      m_owned = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (en[idx] && !found) begin
          found = 1'b1; m_owned = 1'b1; m_owner = idx;
          e_bus = d[idx*W +: W]; e_valid = 1'b1; e_grant[idx] = 1'b1;
        end
      end
    end
    m_bus = e_bus;
    e_con = (e_mask != '0);
    if (clr) begin m_cnt = '0; m_sticky = 1'b0; end
    else if (e_con) begin m_sticky = 1'b1; if (m_cnt != '1) m_cnt = m_cnt + 1'b1; end
    exp_q.push_back({e_bus, e_valid, e_grant, e_mask, e_con, m_sticky, m_cnt});
  endtask

  task automatic compare_out();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("bus_out",   32'(bus_out),           32'(e[EXP_W-1 -: W]));
    check_eq("bus_valid", 32'(bus_valid),         32'(e[EXP_W-W-1]));
    check_eq("grant",     32'(grant),             32'(e[EXP_W-W-2 -: N]));
    check_eq("mask",      32'(conflict_mask),     32'(e[CW+2+W-1 -: W]));
    check_eq("contention",32'(contention),        32'(e[CW+1]));
    check_eq("sticky",    32'(contention_sticky), 32'(e[CW]));
    check_eq("cnt",       32'(contention_cnt),    32'(e[CW-1:0]));
  endtask

  // driver: apply one cycle of stimulus, predict, then compare after the edge
  task automatic drive_cycle(input bit md, input logic [N-1:0] en, input logic [N*W-1:0] d,
                             input bit clr);
    mode = md; drv_en = en; drv_data = d; clr_stat = clr;
    model_step(md, en, d, clr);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_bus"},   32'(bus_out),           32'd0);
    check_eq({tag, "_valid"}, 32'(bus_valid),         32'd0);
    check_eq({tag, "_grant"}, 32'(grant),             32'd0);
    check_eq({tag, "_mask"},  32'(conflict_mask),     32'd0);
    check_eq({tag, "_con"},   32'(contention),        32'd0);
    check_eq({tag, "_stk"},   32'(contention_sticky), 32'd0);
    check_eq({tag, "_cnt"},   32'(contention_cnt),    32'd0);
    check_eq({tag, "_state"}, 32'(state_dbg),         32'(ST_IDLE));
  endtask

  initial begin
    logic [N*W-1:0] rd;
    rst_n = 1'b0; mode = 1'b0; drv_en = '0; drv_data = '0; clr_stat = 1'b0;
    model_reset();
    #12;
    check_reset_outs("reset");
    rst_n = 1'b1;

    // 1: agreeing drivers
    drive_cycle(1'b0, 4'b0011, pack4(8'hA5, 8'hA5, 8'h00, 8'hFF), 1'b0);
    check_eq("t1_bus", 32'(bus_out), 32'hA5);
    check_eq("t1_mask", 32'(conflict_mask), 32'h00);

    // 2: full disagreement, lowest index wins
    drive_cycle(1'b0, 4'b0011, pack4(8'hF0, 8'h0F, 8'h00, 8'h00), 1'b0);
    check_eq("t2_bus", 32'(bus_out), 32'hF0);
    check_eq("t2_mask", 32'(conflict_mask), 32'hFF);
    check_eq("t2_cnt", 32'(contention_cnt), 32'd1);

    // 3: undriven keeps value, then clear races a conflict
    drive_cycle(1'b0, 4'b0000, pack4(8'h11, 8'h22, 8'h33, 8'h44), 1'b0);
    check_eq("t3_keep", 32'(bus_out), 32'hF0);
    check_eq("t3_valid", 32'(bus_valid), 32'd0);
    drive_cycle(1'b0, 4'b0110, pack4(8'h00, 8'h81, 8'h18, 8'h00), 1'b1);
    check_eq("t3_clr_cnt", 32'(contention_cnt), 32'd0);
    check_eq("t3_clr_pulse", 32'(contention), 32'd1);

    // 4: round-robin hand-off with no bubble
    drive_cycle(1'b1, 4'b1111, pack4(8'h10, 8'h21, 8'h32, 8'h43), 1'b0);
    check_eq("t4_first", 32'(grant), 32'b0001);
    for (int o = 0; o < N; o++) begin
      drive_cycle(1'b1, 4'b1111, pack4(8'h10, 8'h21, 8'h32, 8'h43), 1'b0);
      drive_cycle(1'b1, 4'b1111 & ~(4'b0001 << o), pack4(8'h10, 8'h21, 8'h32, 8'h43), 1'b0);
      check_eq("t4_handoff", 32'(grant), 32'(4'b0001 << ((o + 1) % N)));
      check_eq("t4_nobubble", 32'(bus_valid), 32'd1);
    end

    // 5: counter saturation
    for (int k = 0; k < 5; k++)
      drive_cycle(1'b0, 4'b1001, pack4(8'h01, 8'h00, 8'h00, 8'h02), 1'b0);
    check_eq("t5_sat", 32'(contention_cnt), 32'd3);
    drive_cycle(1'b0, 4'b1001, pack4(8'h01, 8'h00, 8'h00, 8'h02), 1'b0);
    check_eq("t5_hold", 32'(contention_cnt), 32'd3);

    // 6: reset mid-ownership; rr_ptr is left at 2 first so its reset is observable
    drive_cycle(1'b1, 4'b0010, pack4(8'h00, 8'h5A, 8'hC3, 8'h00), 1'b0);
    drive_cycle(1'b1, 4'b0000, pack4(8'h00, 8'h5A, 8'hC3, 8'h00), 1'b0);
    drive_cycle(1'b1, 4'b0100, pack4(8'h00, 8'h5A, 8'hC3, 8'h00), 1'b0);
    check_eq("t6_owner2", 32'(grant), 32'b0100);
    rst_n = 1'b0;
    #1;
    check_reset_outs("t6_rst");
    model_reset();
    #1 rst_n = 1'b1;
    drive_cycle(1'b1, 4'b0110, pack4(8'h00, 8'h5A, 8'hC3, 8'h00), 1'b0);
    check_eq("t6_regrant", 32'(grant), 32'b0010);

    // random mix of modes, enables and clears
    for (int k = 0; k < 200; k++) begin
      for (int j = 0; j < N; j++)
        rd[j*W +: W] = ($urandom_range(0, 2) == 0) ? W'($urandom) : 8'h3C;
      drive_cycle(1'($urandom_range(0, 1)), N'($urandom_range(0, 15)), rd,
                  ($urandom_range(0, 15) == 0));
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
